// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry
// common to the receiver and the future transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so idle-high and idle-low lines can share it.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability chain: d -> meta_r -> sync_r
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start validation, mid-bit data sampling, stop
// check, and a single-entry valid/ready holding register with error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_r;
    logic [TW-1:0]        tick_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 stop_hit_s;
    logic                 frame_ok_s;
    logic                 frame_bad_s;
    logic                 drain_s;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .Clk    (Clk),
        .Resetn (Resetn),
        .d      (rx),
        .q      (rx_s)
    );

    // Stop-bit sample point and holding-register handshake decode
    always_comb begin
        stop_hit_s = 1'b0;
        if (baud_tick && (state_r == STOP) && (tick_cnt_r == TICK_LAST)) begin
            stop_hit_s = 1'b1;
        end else begin
            stop_hit_s = 1'b0;
        end
        frame_ok_s  = stop_hit_s & rx_s;
        frame_bad_s = stop_hit_s & ~rx_s;
        drain_s     = rx_valid & rx_ready;
    end

    // Frame FSM: everything advances only on baud_tick
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_r    <= IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {DATA_BITS{1'b0}};
        end else if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r    <= START;
                        tick_cnt_r <= TICK_ZERO;
                    end
                end
                START: begin
                    if (tick_cnt_r == TICK_MID) begin
                        // Still low at mid start bit: genuine frame; else a glitch
                        state_r    <= rx_s ? IDLE : DATA;
                        tick_cnt_r <= TICK_ZERO;
                        bit_cnt_r  <= BIT_ZERO;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    end
                end
                DATA: begin
                    tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    if (tick_cnt_r == TICK_LAST) begin
                        shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= STOP;
                        end
                    end
                end
                STOP: begin
                    tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    if (tick_cnt_r == TICK_LAST) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tick_cnt_r <= TICK_ZERO;
                end
            endcase
        end
    end

    // Holding register and one-cycle error pulses
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            rx_data     <= {DATA_BITS{1'b0}};
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= frame_bad_s;
            overrun     <= frame_ok_s & rx_valid & ~rx_ready;
            if (frame_ok_s && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
            end else if (drain_s) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are serialised bit by bit,
// expected bytes/flags are queued at issue time and matched by a monitor.
module tb_uart_rx;

    localparam int CLK_PER_TICK = 4;
    localparam int BIT_CLKS     = 16 * CLK_PER_TICK;
    localparam int K_FE         = 0;
    localparam int K_OVR        = 1;

    logic       Clk;
    logic       Resetn;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;

    int         n_tests;
    int         n_fail;
    logic [7:0] data_q[$];
    int         flag_q[$];
    bit         model_full;

    uart_rx dut (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        int tcnt;
        tcnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge Clk);
            tcnt++;
            baud_tick = ((tcnt % CLK_PER_TICK) == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_clks(n * BIT_CLKS);
    endtask

    // Serialise one 8N1 frame; the expectation is decided from the frame's
    // contents and the consumer's readiness before the stop bit is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        if (!stop_bit) begin
            flag_q.push_back(K_FE);
        end else if (model_full && !rx_ready) begin
            flag_q.push_back(K_OVR);
        end else begin
            data_q.push_back(b);
            model_full = 1'b1;
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    // Monitor: samples just after the falling edge, when inputs have settled
    initial begin
        logic [7:0] exp_b;
        int         exp_k;
        forever begin
            @(negedge Clk);
            #1;
            if (Resetn) begin
                if (rx_valid && rx_ready) begin
                    n_tests++;
                    if (data_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h expected none", rx_data);
                    end else begin
                        exp_b = data_q.pop_front();
                        if (rx_data !== exp_b) begin
                            n_fail++;
                            $display("FAIL rx_data: got %02h expected %02h", rx_data, exp_b);
                        end
                    end
                    model_full = 1'b0;
                end
                if (frame_error || overrun) begin
                    n_tests++;
                    if (frame_error && overrun) begin
                        n_fail++;
                        $display("FAIL both_flags: got fe=1 ovr=1 expected only one");
                    end else if (flag_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_flag: got fe=%0b ovr=%0b expected none",
                                 frame_error, overrun);
                    end else begin
                        exp_k = flag_q.pop_front();
                        if ((frame_error ? K_FE : K_OVR) != exp_k) begin
                            n_fail++;
                            $display("FAIL flag_kind: got fe=%0b ovr=%0b expected kind %0d",
                                     frame_error, overrun, exp_k);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       sb;
        n_tests    = 0;
        n_fail     = 0;
        model_full = 1'b0;
        Resetn     = 1'b0;
        rx         = 1'b1;
        rx_ready   = 1'b1;
        wait_clks(3);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        Resetn = 1'b1;
        idle_bits(2);

        // Basic byte, then a short start glitch, then a bad stop bit
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        rx = 1'b0;
        wait_clks(4 * CLK_PER_TICK);
        idle_bits(3);
        check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        check("fe_no_valid", {31'd0, rx_valid}, 32'd0);

        // Overrun while the consumer stalls
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_bits(1);
        check("held_valid", {31'd0, rx_valid}, 32'd1);
        check("held_data", {24'd0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        wait_clks(3);
        check("drained_valid", {31'd0, rx_valid}, 32'd0);
        idle_bits(1);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle_bits(2);

        // Reset in the middle of a frame while a byte is held
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        idle_bits(1);
        check("prereset_valid", {31'd0, rx_valid}, 32'd1);
        b = 8'hC3;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = b[4];
        wait_clks(BIT_CLKS / 2);
        Resetn = 1'b0;
        rx     = 1'b1;
        data_q.delete();
        flag_q.delete();
        model_full = 1'b0;
        wait_clks(2);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_flags", {30'd0, frame_error, overrun}, 32'd0);
        Resetn   = 1'b1;
        rx_ready = 1'b1;
        idle_bits(2);
        send_frame(8'h81, 1'b1);
        idle_bits(2);

        // Random frames: random data, occasional bad stop, random stalls and gaps
        for (int n = 0; n < 24; n++) begin
            b        = 8'($urandom_range(0, 255));
            sb       = ($urandom_range(0, 9) != 0);
            rx_ready = ($urandom_range(0, 3) != 0);
            send_frame(b, sb);
            if (sb) begin
                idle_bits(int'($urandom_range(0, 1)));
            end else begin
                idle_bits(2);
            end
        end
        rx_ready = 1'b1;
        idle_bits(3);

        check("data_queue_empty", data_q.size(), 32'd0);
        check("flag_queue_empty", flag_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampling UART receiver: the far end of the serial link whose timebase is the shared baud-tick generator. Synchronises the asynchronous `rx` line, validates start bit, samples data bits at mid-bit and checks stop bit, presenting each byte through a single-entry valid/ready holding register with frame-error and overrun flags. Sits between the pad and the AXI-Lite register block that drains received bytes.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; legal 5–8.
- `OVERSAMPLE`, 16: `baud_tick` strobes per bit period; power of two, ≥ 8.

- `Clk`  in  1  system clock.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `baud_tick`  in  1  one-`Clk`-wide strobe at OVERSAMPLE × baud rate.
- `rx`  in  1  serial input, asynchronous, idle high.
- `rx_data`  out  DATA_BITS  received byte; valid while `rx_valid`.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `frame_error`  out  1  1-cycle pulse: stop bit sampled low.
- `overrun`  out  1  1-cycle pulse: byte completed while holding register full and not drained.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) → `rx_s`; all decisions use `rx_s`.
- Counters: `tick_cnt` width log2(OVERSAMPLE), `bit_cnt` width log2(DATA_BITS) rounded up; both advance only on `baud_tick`.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: on `baud_tick` with `rx_s==0` → START, `tick_cnt=0`.
  - START: on tick, `tick_cnt++`; at `tick_cnt==OVERSAMPLE/2-1` sample: `rx_s==0` → DATA, `tick_cnt=0`, `bit_cnt=0`; `rx_s==1` → IDLE (glitch rejected, no flag).
  - DATA: on tick, `tick_cnt++` (wraps); at `tick_cnt==OVERSAMPLE-1` shift `rx_s` into MSB of shift register (shift right), `bit_cnt++`; after bit DATA_BITS-1 → STOP.
  - STOP: at `tick_cnt==OVERSAMPLE-1` sample: `rx_s==1` → completion; `rx_s==0` → `frame_error` pulse, byte discarded. Either way → IDLE.
- Completion: holding register empty, or drained the same cycle (`rx_valid && rx_ready`) → load `rx_data`, `rx_valid=1`. Full and not drained → `overrun` pulse, new byte dropped, old byte kept.
- `rx_valid` clears on `rx_valid && rx_ready` with no simultaneous completion.
- `rx_data` stable while `rx_valid` held.
- Frame error and overrun never both pulse for one frame (frame error wins; byte not offered).

## Timing
- Reset: FSM IDLE, counters 0, synchroniser 1, `rx_data=0`, `rx_valid=0`, `frame_error=0`, `overrun=0`. Reset mid-frame aborts frame, clears holding register.
- `rx` edge → `rx_s` in 2 `Clk`.
- `rx_valid` / `frame_error` / `overrun` assert the `Clk` after the `baud_tick` on which the stop bit is sampled.
- Stop sampled at tick OVERSAMPLE-1 of stop bit (≈ mid-bit relative to start mid-point); receiver returns to IDLE early, so back-to-back frames with no idle gap are received.
- `baud_tick` ignored while `Resetn` low; `rx_ready` without `rx_valid` has no effect.

## Structure
- Package `uart_pkg`: `uart_rx_state_t` enum (IDLE, START, DATA, STOP), default `OVERSAMPLE`/`DATA_BITS` constants shared with the future transmitter.
- Sub-module `uart_sync`: 2-flop synchroniser with parametric reset value; reused by the transmitter's CTS path.

## Test plan
- 0xA5, 8N1, `baud_tick` every 4 `Clk`, `rx_ready=1` → one `rx_valid` cycle, `rx_data=0xA5`, no flags.
- `rx` low for 4 ticks then high → no `rx_valid`, no `frame_error`, FSM back in IDLE.
- 0x3C with stop bit driven 0 → `frame_error` single pulse, `rx_valid` stays 0.
- 0x11 then 0x22, `rx_ready=0` → `rx_valid=1`, `rx_data=0x11`, `overrun` pulse at second stop; assert `rx_ready` → 0x11 accepted, `rx_valid` drops.
- Back-to-back 0x00, 0xFF, 0x55 with zero idle gap, `rx_ready=1` → three bytes in order, no flags.
- `Resetn` pulsed low during DATA bit 4 → all outputs 0; next clean frame 0x81 received correctly.
